// File: rtl/bloco_operativo.sv
// bloco_operativo: datapath paired with the blocoControle FSM.
// Holds din_q, X, Hr, S and executes one ALU op per cycle as commanded by
// M0/M1/M2/LX/LH/LS/H; publishes S on a pronto rising edge with a valid pulse.
// Optional macro BLOCO_OPERATIVO_SAT_EN selects saturating arithmetic
// (default build wraps modulo 2^WIDTH; ovf behaves identically either way).
module bloco_operativo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned K     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       M0,
  input  logic [1:0]       M1,
  input  logic [1:0]       M2,
  input  logic             LX,
  input  logic             LH,
  input  logic             LS,
  input  logic             H,
  input  logic             pronto,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             ovf
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] KC = WIDTH'(K);

  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] hr_q, hr_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             ovf_q, ovf_d;
  logic             pronto_dly_q, pronto_dly_d;

  logic [WIDTH-1:0] op_a_c, op_b_c, alu_c;
  logic             alu_ovf_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    prod_c;
  logic             rise_c;

  // Operand muxes
  always_comb begin
    op_a_c = x_q;
    op_b_c = '0;
    case (M0)
      2'd0: op_a_c = x_q;
      2'd1: op_a_c = hr_q;
      2'd2: op_a_c = s_q;
      default: op_a_c = KC;
    endcase
    case (M1)
      2'd0: op_b_c = '0;
      2'd1: op_b_c = x_q;
      2'd2: op_b_c = s_q;
      default: op_b_c = hr_q;
    endcase
  end

  // ALU with overflow detection; saturation is a build-time option
  always_comb begin
    sum_c     = {1'b0, op_a_c} + {1'b0, op_b_c};
    prod_c    = PW'(op_a_c) * PW'(op_b_c);
    alu_c     = op_a_c;
    alu_ovf_c = 1'b0;
    case (M2)
      2'd0: begin
        alu_ovf_c = sum_c[WIDTH];
        alu_c     = sum_c[WIDTH-1:0];
`ifdef BLOCO_OPERATIVO_SAT_EN
        if (alu_ovf_c) alu_c = {WIDTH{1'b1}};
`endif
      end
      2'd1: begin
        alu_ovf_c = |prod_c[PW-1:WIDTH];
        alu_c     = prod_c[WIDTH-1:0];
`ifdef BLOCO_OPERATIVO_SAT_EN
        if (alu_ovf_c) alu_c = {WIDTH{1'b1}};
`endif
      end
      2'd2: begin
        alu_ovf_c = (op_a_c < op_b_c);
        alu_c     = op_a_c - op_b_c;
`ifdef BLOCO_OPERATIVO_SAT_EN
        if (alu_ovf_c) alu_c = '0;
`endif
      end
      default: begin
        alu_ovf_c = 1'b0;
        alu_c     = op_a_c;
      end
    endcase
  end

  // Register next-state: every write is commanded by a control input
  always_comb begin
    din_d        = H ? din_q : din;
    x_d          = LX ? din_q : x_q;
    hr_d         = LH ? alu_c : hr_q;
    s_d          = LS ? alu_c : s_q;
    pronto_dly_d = pronto;
    rise_c       = pronto & ~pronto_dly_q;
    dout_d       = rise_c ? s_q : dout_q;
    dout_valid_d = rise_c;
    // New computation clears the flag; a same-cycle overflow still sets it
    ovf_d = ovf_q;
    if (LX) ovf_d = 1'b0;
    if ((LH | LS) & alu_ovf_c) ovf_d = 1'b1;
  end

  // State registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q        <= '0;
      x_q          <= '0;
      hr_q         <= '0;
      s_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      pronto_dly_q <= 1'b0;
    end else begin
      din_q        <= din_d;
      x_q          <= x_d;
      hr_q         <= hr_d;
      s_q          <= s_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
      pronto_dly_q <= pronto_dly_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_bloco_operativo.sv
// Directed self-checking bench for bloco_operativo (WIDTH=8, K=3).
module tb_bloco_operativo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [1:0] M0, M1, M2;
  logic       LX, LH, LS, H, pronto;
  logic [7:0] dout;
  logic       dout_valid;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  bloco_operativo #(.WIDTH(8), .K(3)) dut (
    .clk(clk), .rst(rst), .din(din), .M0(M0), .M1(M1), .M2(M2),
    .LX(LX), .LH(LH), .LS(LS), .H(H), .pronto(pronto),
    .dout(dout), .dout_valid(dout_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one control word for one edge, then return to idle
  task automatic ctl(input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                     input logic lx, input logic lh, input logic ls);
    M0 = m0; M1 = m1; M2 = m2; LX = lx; LH = lh; LS = ls;
    tick();
    LX = 1'b0; LH = 1'b0; LS = 1'b0;
  endtask

  // Capture din into din_q, then hold it and load X
  task automatic load_x(input logic [7:0] v);
    din = v; H = 1'b0;
    tick();
    H = 1'b1; LX = 1'b1;
    tick();
    LX = 1'b0; H = 1'b0;
  endtask

  // Pulse pronto and check the published S value
  task automatic publish(input string tag, input logic [7:0] exp);
    pronto = 1'b1;
    tick();
    check({tag, "_valid"}, 32'(dout_valid), 32'd1);
    check({tag, "_dout"}, 32'(dout), 32'(exp));
    pronto = 1'b0;
    tick();
    check({tag, "_valid_drop"}, 32'(dout_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; din = '0; M0 = '0; M1 = '0; M2 = '0;
    LX = 1'b0; LH = 1'b0; LS = 1'b0; H = 1'b0; pronto = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // X=5, S=X*X=25
    load_x(8'd5);
    ctl(2'd0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1);
    check("mul_ovf", 32'(ovf), 32'd0);
    publish("mul25", 8'd25);

    // 200+200 overflows
    load_x(8'd200);
    ctl(2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
    check("add_ovf", 32'(ovf), 32'd1);
`ifdef BLOCO_OPERATIVO_SAT_EN
    publish("add_sat", 8'd255);
`else
    publish("add_wrap", 8'd144);
`endif
    check("ovf_sticky", 32'(ovf), 32'd1);
    load_x(8'd5);
    check("ovf_clr_lx", 32'(ovf), 32'd0);

    // S=5, X=3, Hr=X-S underflows; then S=K+Hr
    ctl(2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
    load_x(8'd3);
    ctl(2'd0, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0);
    check("sub_ovf", 32'(ovf), 32'd1);
    ctl(2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
`ifdef BLOCO_OPERATIVO_SAT_EN
    publish("sub_sat", 8'd0);
    ctl(2'd3, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1);
    publish("k_plus_hr", 8'd3);
`else
    publish("sub_wrap", 8'd254);
    ctl(2'd3, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1);
    publish("k_plus_hr", 8'd1);
`endif

    // pronto held 3 cycles: single pulse; re-rise gives a second one
    load_x(8'd5);
    ctl(2'd0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1);
    pronto = 1'b1;
    tick();
    check("hold_p1", 32'(dout_valid), 32'd1);
    check("hold_dout", 32'(dout), 32'd25);
    tick();
    check("hold_c2", 32'(dout_valid), 32'd0);
    tick();
    check("hold_c3", 32'(dout_valid), 32'd0);
    pronto = 1'b0;
    tick();
    check("low_c", 32'(dout_valid), 32'd0);
    pronto = 1'b1;
    tick();
    check("rerise_valid", 32'(dout_valid), 32'd1);
    check("rerise_dout", 32'(dout), 32'd25);
    pronto = 1'b0;
    tick();

    // pronto rise together with LS loading 40: old S published
    load_x(8'd40);
    pronto = 1'b1;
    ctl(2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
    check("same_valid", 32'(dout_valid), 32'd1);
    check("same_dout", 32'(dout), 32'd25);
    pronto = 1'b0;
    tick();
    publish("s40", 8'd40);

    // LX with LS: S uses the old X (40+40), X becomes 7
    din = 8'd7; H = 1'b0;
    tick();
    H = 1'b1;
    ctl(2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1);
    H = 1'b0;
    publish("old_x", 8'd80);
    ctl(2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
    publish("new_x", 8'd7);

    // Control codes with no load change nothing
    ctl(2'd3, 2'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    ctl(2'd2, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    publish("noload", 8'd7);
    check("noload_ovf", 32'(ovf), 32'd0);

    // LX clear and overflow set together: set wins; S = old X^2
    load_x(8'd20);
    din = 8'd50; H = 1'b0;
    tick();
    ctl(2'd0, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1);
    check("set_wins", 32'(ovf), 32'd1);
`ifdef BLOCO_OPERATIVO_SAT_EN
    publish("mul_sat", 8'd255);
`else
    publish("mul_wrap", 8'd144);
`endif

    // Reset during LS of 99, with ovf and dout nonzero
    load_x(8'd99);
    ctl(2'd0, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0);
    check("pre_rst_ovf", 32'(ovf), 32'd1);
    rst = 1'b1;
    ctl(2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_valid", 32'(dout_valid), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    publish("midrst_s", 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bloco_operativo.md
# bloco_operativo

Datapath paired with the `blocoControle` FSM. It consumes the control word `M0/M1/M2/LX/LH/LS/H/pronto`, holds the operand and intermediate registers, and executes one ALU operation per cycle as commanded. When `pronto` rises, it publishes the final result with a one-cycle valid pulse. The block contains no sequencing decisions of its own: every register write is commanded by the control inputs.

## Interface
Parameters:
- `WIDTH`, 8 — datapath width; all registers and ALU results are `WIDTH` bits, unsigned.
- `K`, 3 — constant operand selectable on operand mux A; truncated to `WIDTH` bits.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  WIDTH  external operand.
- `M0`  in  2  operand A select: 0=X, 1=Hr, 2=S, 3=K.
- `M1`  in  2  operand B select: 0=zero, 1=X, 2=S, 3=Hr.
- `M2`  in  2  ALU op: 0=A+B, 1=A*B (low WIDTH bits), 2=A−B, 3=pass A.
- `LX`  in  1  load X from `din_q`.
- `LH`  in  1  load Hr from ALU result.
- `LS`  in  1  load S from ALU result.
- `H`  in  1  hold: 1 freezes input capture register `din_q`.
- `pronto`  in  1  computation-finished level from the FSM.
- `dout`  out  WIDTH  published result.
- `dout_valid`  out  1  one-cycle pulse; `dout` is new.
- `ovf`  out  1  sticky arithmetic overflow/underflow flag.

## Operation
- Internal registers: `din_q`, `X`, `Hr`, `S`, `pronto_d`. All of these and every output reset to 0.
- `din_q <= din` on every cycle with `H=0`. It holds when `H=1`.
- The ALU is combinational from current register values; `alu = op(A,B)` per `M0/M1/M2`.
- Overflow conditions:
  - `op=0`: carry out of bit WIDTH−1.
  - `op=1`: full 2·WIDTH product ≥ 2^WIDTH.
  - `op=2`: A < B.
  - `op=3`: never.
- `ovf` sets on any cycle where `LH` or `LS` is asserted and the current op overflows. `ovf` clears on `LX=1`, which marks a new computation. If both happen in the same cycle, set wins.
- `LX`, `LH` and `LS` are independent. Any combination loads in the same cycle; `LH` and `LS` together both take the same `alu` value.
- All ALU operands use pre-edge register values. Example: `LX` with `LS` computes S from the old X.
- `pronto` rise detect: `pronto & ~pronto_d`.
  - On that edge: `dout <= S` (pre-edge value) and `dout_valid <= 1`.
  - Otherwise: `dout_valid <= 0` and `dout` holds.
  - If `LS` asserts in the same cycle as the rise, `dout` gets the old S and S updates.
- `pronto` held high for N cycles produces exactly one `dout_valid` pulse. A new pulse requires `pronto` to go low for at least one cycle and then rise again.
- Control codes arriving with no load asserted change nothing. The ALU result is simply discarded.

## Timing
- Load latency is 1 cycle: a register written at edge n is visible to the ALU in cycle n+1.
- `din` to X takes at least 2 edges: edge 1 captures `din_q` (H=0), edge 2 applies `LX`. If H is 1 throughout, X takes the stale `din_q`.
- `pronto` to `dout_valid` is 1 cycle. `dout_valid` is high for exactly 1 cycle.
- `rst` has priority over all controls. Asserted mid-computation, all registers and outputs are 0 after that edge and the pending load is lost.
- `ovf` updates at the same edge as the offending load.

## Configuration
- Macro: `BLOCO_OPERATIVO_SAT_EN`.
- Defined: saturating arithmetic.
  - Add and mul overflow clamp to 2^WIDTH−1.
  - Sub underflow clamps to 0.
  - `ovf` is still set on the same conditions.
- Undefined: modulo 2^WIDTH wrap. `ovf` behaviour is identical.

## Test plan
- Reset, then `din=5` with H=0 for 1 cycle, then H=1 with LX=1 → X=5. Then `M0=0,M1=1,M2=1,LS=1` → S=25, ovf=0.
- X=200, `M0=0,M1=1,M2=0,LS=1` → S=144 wrap with ovf=1; under `SAT_EN`, S=255 with ovf=1. A following LX=1 clears ovf to 0.
- X=3, S=5, `M0=0,M1=2,M2=2,LH=1` → Hr=254 wrap with ovf=1; under `SAT_EN`, Hr=0. Then `M0=3,M1=3,M2=0,LS=1` → S=K+Hr (1 wrap, or 3 with `SAT_EN`).
- S=25, `pronto` high for 3 cycles → `dout=25` and `dout_valid` high for exactly 1 cycle, 1 cycle after the rise. `pronto` low for 1 cycle then high again → a second pulse.
- `pronto` rises in the same cycle as LS loading 40 over S=25 → `dout=25` and S=40.
- `rst` asserted in the cycle LS loads 99 → S=0, dout=0, dout_valid=0, ovf=0 after that edge.
